// File: rtl/r_type_pkg.sv
// Purpose: shared constants, op-index enum and R-type decode helper for the decode stage.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package r_type_pkg;

  localparam int NUM_REGS = 32;
  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_OPS  = 10;

  localparam logic [6:0] OPCODE_R   = 7'b0110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_OR   = 4'd2,
    OP_XOR  = 4'd3,
    OP_AND  = 4'd4,
    OP_SLT  = 4'd5,
    OP_SLTU = 4'd6,
    OP_SLL  = 4'd7,
    OP_SRL  = 4'd8,
    OP_SRA  = 4'd9
  } op_idx_e;

  // One-hot op vector indexed by op_idx_e; all-zero means the word is not a supported R-type.
  function automatic logic [NUM_OPS-1:0] decode_op(input logic [XLEN-1:0] instr);
    logic [NUM_OPS-1:0] oh;
    oh = '0;
    if (instr[6:0] == OPCODE_R) begin
      case ({instr[31:25], instr[14:12]})
        {F7_BASE, F3_ADD_SUB}: oh[OP_ADD]  = 1'b1;
        {F7_ALT,  F3_ADD_SUB}: oh[OP_SUB]  = 1'b1;
        {F7_BASE, F3_SLL}:     oh[OP_SLL]  = 1'b1;
        {F7_BASE, F3_SLT}:     oh[OP_SLT]  = 1'b1;
        {F7_BASE, F3_SLTU}:    oh[OP_SLTU] = 1'b1;
        {F7_BASE, F3_XOR}:     oh[OP_XOR]  = 1'b1;
        {F7_BASE, F3_SRL_SRA}: oh[OP_SRL]  = 1'b1;
        {F7_ALT,  F3_SRL_SRA}: oh[OP_SRA]  = 1'b1;
        {F7_BASE, F3_OR}:      oh[OP_OR]   = 1'b1;
        {F7_BASE, F3_AND}:     oh[OP_AND]  = 1'b1;
        default:               oh          = '0;
      endcase
    end
    return oh;
  endfunction

endpackage

// File: rtl/reg_file_32x32.sv
// Purpose: 32x32 integer register file, two combinational read ports, one write port, x0 hardwired to 0.
// Latency: reads combinational; write visible after the clock edge that performs it.
// Backpressure: none; the write port is a plain strobe.
module reg_file_32x32
  import r_type_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [XLEN-1:0]   rdata1,
  output logic [XLEN-1:0]   rdata2
);

  logic [XLEN-1:0] mem [NUM_REGS];

  // Synchronous clear of every register; writes to x0 are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : mem[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : mem[raddr2];

endmodule

// File: rtl/r_decode_stage.sv
// Purpose: RV32 R-type decode with register-file operand read; optional write-back bypass under R_DECODE_BYPASS_EN.
// Latency: 1 cycle from accept to out_valid.
// Backpressure: valid/ready; bundle held stable while out_valid && !out_ready, instr_ready = !out_valid || out_ready.
module r_decode_stage
  import r_type_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [XLEN-1:0]   instr,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              Radd_en,
  output logic              Rsub_en,
  output logic              Ror_en,
  output logic              Rxor_en,
  output logic              Rand_en,
  output logic              Rslt_en,
  output logic              Rsltu_en,
  output logic              Rsll_en,
  output logic              Rsrl_en,
  output logic              Rsra_en,
  output logic [XLEN-1:0]   read_data1,
  output logic [XLEN-1:0]   read_data2,
  output logic [REG_AW-1:0] rd_addr,
  output logic              illegal
);

  logic [REG_AW-1:0]  rs1;
  logic [REG_AW-1:0]  rs2;
  logic [XLEN-1:0]    rf_rdata1;
  logic [XLEN-1:0]    rf_rdata2;
  logic [XLEN-1:0]    opnd1;
  logic [XLEN-1:0]    opnd2;
  logic [NUM_OPS-1:0] op_oh;
  logic               dec_illegal;
  logic               accept;
  logic [NUM_OPS-1:0] en_q;

  assign rs1         = instr[19:15];
  assign rs2         = instr[24:20];
  assign op_oh       = decode_op(instr);
  assign dec_illegal = (op_oh == '0);
  assign instr_ready = !out_valid || out_ready;
  assign accept      = instr_valid && instr_ready;

  reg_file_32x32 u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (wb_en),
    .waddr  (wb_rd),
    .wdata  (wb_data),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rf_rdata1),
    .rdata2 (rf_rdata2)
  );

`ifdef R_DECODE_BYPASS_EN
  // A write-back landing on a source register this cycle forwards its value directly.
  assign opnd1 = (wb_en && (wb_rd == rs1) && (rs1 != '0)) ? wb_data : rf_rdata1;
  assign opnd2 = (wb_en && (wb_rd == rs2) && (rs2 != '0)) ? wb_data : rf_rdata2;
`else
  // Without forwarding the operand is the register value before this cycle's write.
  assign opnd1 = rf_rdata1;
  assign opnd2 = rf_rdata2;
`endif

  // Capture the decoded bundle on accept; hold it untouched until the ALU drains it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      illegal    <= 1'b0;
      en_q       <= '0;
      read_data1 <= '0;
      read_data2 <= '0;
      rd_addr    <= '0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      illegal    <= dec_illegal;
      en_q       <= op_oh;
      read_data1 <= dec_illegal ? '0 : opnd1;
      read_data2 <= dec_illegal ? '0 : opnd2;
      rd_addr    <= dec_illegal ? '0 : instr[11:7];
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  assign Radd_en  = en_q[OP_ADD];
  assign Rsub_en  = en_q[OP_SUB];
  assign Ror_en   = en_q[OP_OR];
  assign Rxor_en  = en_q[OP_XOR];
  assign Rand_en  = en_q[OP_AND];
  assign Rslt_en  = en_q[OP_SLT];
  assign Rsltu_en = en_q[OP_SLTU];
  assign Rsll_en  = en_q[OP_SLL];
  assign Rsrl_en  = en_q[OP_SRL];
  assign Rsra_en  = en_q[OP_SRA];

endmodule

// File: tb/tb_r_decode_stage.sv
// Purpose: bench for r_decode_stage; behavioural register/bundle model plus directed literal checks.
// Latency: expects bundle one cycle after accept.
// Backpressure: randomizes out_ready and instr_valid; honours R_DECODE_BYPASS_EN when defined.
module tb_r_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic        Radd_en, Rsub_en, Ror_en, Rxor_en, Rand_en;
  logic        Rslt_en, Rsltu_en, Rsll_en, Rsrl_en, Rsra_en;
  logic [31:0] read_data1, read_data2;
  logic [4:0]  rd_addr;
  logic        illegal;

  always #5 clk = ~clk;

  r_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .Radd_en(Radd_en), .Rsub_en(Rsub_en), .Ror_en(Ror_en), .Rxor_en(Rxor_en), .Rand_en(Rand_en),
    .Rslt_en(Rslt_en), .Rsltu_en(Rsltu_en), .Rsll_en(Rsll_en), .Rsrl_en(Rsrl_en), .Rsra_en(Rsra_en),
    .read_data1(read_data1), .read_data2(read_data2), .rd_addr(rd_addr), .illegal(illegal)
  );

  // Enable vector as seen by the bench: bit 9 = add ... bit 0 = sra.
  wire [9:0] dut_en = {Radd_en, Rsub_en, Ror_en, Rxor_en, Rand_en,
                       Rslt_en, Rsltu_en, Rsll_en, Rsrl_en, Rsra_en};

  // Operation table in the same order as dut_en (add first).
  logic [6:0] tab_f7 [10] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20};
  logic [2:0] tab_f3 [10] = '{3'd0,  3'd0,  3'd6,  3'd4,  3'd7,  3'd2,  3'd3,  3'd1,  3'd5,  3'd5};

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_op(input logic [31:0] w);
    int r;
    r = -1;
    if (w[6:0] == 7'b0110011)
      for (int i = 0; i < 10; i++)
        if (w[31:25] == tab_f7[i] && w[14:12] == tab_f3[i]) r = i;
    return r;
  endfunction

  // Behavioural model state.
  logic [31:0] m_regs [32];
  bit          m_valid, m_after_rst, m_ill;
  logic [9:0]  m_en;
  logic [31:0] m_rd1, m_rd2;
  logic [4:0]  m_rdaddr;

  function automatic logic [31:0] model_read(input logic [4:0] rs);
    logic [31:0] v;
    if (rs == 5'd0) return 32'd0;
    v = m_regs[rs];
`ifdef R_DECODE_BYPASS_EN
    if (wb_en && wb_rd == rs) v = wb_data;
`endif
    return v;
  endfunction

  // Model advances on each rising edge using the inputs held across that edge.
  always @(posedge clk) begin
    int op;
    if (!rst_n) begin
      m_valid = 0; m_after_rst = 1; m_ill = 0; m_en = '0;
      m_rd1 = '0; m_rd2 = '0; m_rdaddr = '0;
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
    end else begin
      if (instr_valid && (!m_valid || out_ready)) begin
        op = model_op(instr);
        m_valid = 1; m_after_rst = 0;
        if (op < 0) begin
          m_ill = 1; m_en = '0; m_rd1 = '0; m_rd2 = '0; m_rdaddr = '0;
        end else begin
          m_ill = 0; m_en = 10'b10_0000_0000 >> op;
          m_rd1 = model_read(instr[19:15]);
          m_rd2 = model_read(instr[24:20]);
          m_rdaddr = instr[11:7];
        end
      end else if (out_ready) begin
        m_valid = 0;
      end
      if (wb_en && wb_rd != 5'd0) m_regs[wb_rd] = wb_data;
    end
  end

  // Compare DUT against the model every falling edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      check("instr_ready", {31'd0, instr_ready}, {31'd0, (!m_valid || out_ready)});
      if (m_valid || m_after_rst) begin
        check("illegal", {31'd0, illegal}, {31'd0, m_ill});
        check("enables", {22'd0, dut_en}, {22'd0, m_en});
        check("read_data1", read_data1, m_rd1);
        check("read_data2", read_data2, m_rd2);
        check("rd_addr", {27'd0, rd_addr}, {27'd0, m_rdaddr});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    wb_en = 1; wb_rd = r; wb_data = d;
    tick();
    wb_en = 0;
  endtask

  function automatic logic [31:0] rand_instr();
    int k, sel;
    logic [31:0] w;
    k = $urandom_range(0, 9);
    sel = $urandom_range(0, 9);
    w = $urandom;
    if (sel < 7) begin
      w = {tab_f7[k], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), tab_f3[k],
           5'($urandom_range(0, 31)), 7'b0110011};
    end else if (sel == 7) begin
      w[6:0] = 7'b0110011;
    end
    return w;
  endfunction

  initial begin
    logic [31:0] exp_byp;
    rst_n = 0; instr_valid = 0; instr = '0; wb_en = 0; wb_rd = '0; wb_data = '0; out_ready = 0;
    tick();
    chk_on = 1;
    tick();
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst illegal", {31'd0, illegal}, 32'd0);
    check("rst enables", {22'd0, dut_en}, 32'd0);
    check("rst read_data1", read_data1, 32'd0);
    rst_n = 1;
    #1;
    check("rst instr_ready", {31'd0, instr_ready}, 32'd1);

    // Seed x1=9, x2=3, then add x3,x1,x2.
    out_ready = 1;
    wb(5'd1, 32'd9);
    wb(5'd2, 32'd3);
    instr_valid = 1; instr = 32'h002081B3;
    tick();
    check("add en", {22'd0, dut_en}, 32'h200);
    check("add rd1", read_data1, 32'd9);
    check("add rd2", read_data2, 32'd3);
    check("add rd_addr", {27'd0, rd_addr}, 32'd3);
    instr = 32'h402081B3;
    tick();
    check("sub en", {22'd0, dut_en}, 32'h100);
    instr = 32'h4020D1B3;
    tick();
    check("sra en", {22'd0, dut_en}, 32'h001);
    check("sra rd1", read_data1, 32'd9);
    check("sra rd2", read_data2, 32'd3);
    instr = 32'h00000013;
    tick();
    check("ill flag", {31'd0, illegal}, 32'd1);
    check("ill en", {22'd0, dut_en}, 32'd0);
    check("ill rd1", read_data1, 32'd0);

    // Hold: add captured, then stall two cycles while x1 is overwritten.
    instr = 32'h002081B3;
    tick();
    out_ready = 0; instr = 32'h402081B3;
    wb_en = 1; wb_rd = 5'd1; wb_data = 32'h77;
    tick();
    wb_en = 0;
    tick();
    check("hold instr_ready", {31'd0, instr_ready}, 32'd0);
    check("hold en", {22'd0, dut_en}, 32'h200);
    check("hold rd1", read_data1, 32'd9);
    out_ready = 1;
    #1;
    check("release instr_ready", {31'd0, instr_ready}, 32'd1);
    tick();
    check("release en", {22'd0, dut_en}, 32'h100);
    check("release rd1", read_data1, 32'h77);

    // Same-cycle write-back to a source register.
    instr_valid = 0;
    wb(5'd1, 32'd9);
    instr_valid = 1; instr = 32'h002081B3;
    wb_en = 1; wb_rd = 5'd1; wb_data = 32'h55;
    tick();
    wb_en = 0;
`ifdef R_DECODE_BYPASS_EN
    exp_byp = 32'h55;
`else
    exp_byp = 32'd9;
`endif
    check("bypass rd1", read_data1, exp_byp);

    // x0 ignores writes.
    instr_valid = 0;
    wb(5'd0, 32'hFFFF);
    instr_valid = 1; instr = 32'h000001B3;
    tick();
    check("x0 rd1", read_data1, 32'd0);
    check("x0 rd2", read_data2, 32'd0);
    instr_valid = 0;

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      instr_valid = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      instr       = rand_instr();
      wb_en       = $urandom_range(0, 1);
      wb_rd       = 5'($urandom_range(0, 7));
      wb_data     = $urandom;
      tick();
    end
    wb_en = 0;

    // Reset while a bundle is held.
    wb(5'd1, 32'd9);
    out_ready = 1; instr_valid = 1; instr = 32'h002081B3;
    tick();
    out_ready = 0; instr_valid = 0;
    tick();
    rst_n = 0;
    tick();
    check("midrst out_valid", {31'd0, out_valid}, 32'd0);
    rst_n = 1;
    #1;
    check("midrst instr_ready", {31'd0, instr_ready}, 32'd1);
    instr_valid = 1; instr = 32'h000081B3;
    tick();
    check("midrst x1", read_data1, 32'd0);
    instr_valid = 0; out_ready = 1;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/r_decode_stage.md
R_DECODE_STAGE -- requirements
Module: r_decode_stage

Interface
REQ-001 No parameters; 32 registers x 32 bits, RV32 R-type only.
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 instr_valid  input  1  upstream instruction valid.
REQ-005 instr_ready  output  1  stage accepts instruction this cycle.
REQ-006 instr  input  32  raw instruction word.
REQ-007 wb_en  input  1  write-back strobe from ALU stage.
REQ-008 wb_rd  input  5  write-back destination register.
REQ-009 wb_data  input  32  write-back value (alu_out).
REQ-010 out_valid  output  1  decoded bundle valid toward ALU.
REQ-011 out_ready  input  1  ALU stage consumes bundle.
REQ-012 Radd_en, Rsub_en, Ror_en, Rxor_en, Rand_en, Rslt_en, Rsltu_en, Rsll_en, Rsrl_en, Rsra_en  output  1 each  one-hot ALU op enables.
REQ-013 read_data1 / read_data2  output  32 each  rs1 / rs2 operand values.
REQ-014 rd_addr  output  5  destination register of bundle.
REQ-015 illegal  output  1  bundle is not a supported R-type instruction.

Function
REQ-016 The stage SHALL be R-type only when opcode=0110011; funct3/funct7: 000/0000000 add, 000/0100000 sub, 001/0000000 sll, 010/0000000 slt, 011/0000000 sltu, 100/0000000 xor, 101/0000000 srl, 101/0100000 sra, 110/0000000 or, 111/0000000 and.
REQ-017 Any other encoding SHALL produce illegal=1, all enables 0, read_data1/2=0, rd_addr=0.
REQ-018 Valid bundles SHALL assert exactly one enable.
REQ-019 instr_ready SHALL equal !out_valid || out_ready (combinational).
REQ-020 Accept = instr_valid && instr_ready; the bundle SHALL appear registered with out_valid=1 on the next cycle (latency 1).
REQ-021 out_valid SHALL clear after out_ready without a new accept.
REQ-022 Accept and drain in one cycle SHALL sustain 1 instruction/cycle.
REQ-023 While out_valid && !out_ready, all outputs SHALL stay stable, including read_data, with no refresh from later writes.
REQ-024 Register file: write at clock edge when wb_en && wb_rd!=0; reads of x0 SHALL return 0; writes to x0 SHALL be ignored.
REQ-025 Operands SHALL be sampled from the register file in the accept cycle.

Reset
REQ-026 With rst_n=0 at a clock edge: out_valid=0, illegal=0, enables=0, read_data1/2=0, rd_addr=0, and all 32 registers cleared to 0.
REQ-027 Reset mid-hold SHALL drop the pending bundle; instr_ready SHALL read 1 on the cycle after reset deasserts.

Configuration
REQ-028 Macro R_DECODE_BYPASS_EN defined: if wb_en && wb_rd==rs (rs!=0) in the accept cycle, the captured operand SHALL be wb_data.
REQ-029 Macro R_DECODE_BYPASS_EN undefined: the captured operand SHALL be the pre-write register value.

Structure
REQ-030 Package r_type_pkg SHALL hold: OPCODE_R constant, funct3/funct7 constants, an op-index enum for the 10 operations, and the register count/width constants.
REQ-031 The register file SHALL be sub-module reg_file_32x32 (2 read ports, 1 write port, synchronous reset).

Verification
REQ-032 wb x1=9, x2=3; instr 0x002081B3 -> next cycle out_valid=1, only Radd_en=1, read_data1=9, read_data2=3, rd_addr=3.
REQ-033 instr 0x402081B3 -> only Rsub_en=1; instr 0x4020D1B3 -> only Rsra_en=1, operands 9/3.
REQ-034 instr 0x00000013 -> illegal=1, all enables 0, read_data1/2=0.
REQ-035 out_ready=0 for 2 cycles with bundle held -> instr_ready=0, outputs unchanged; out_ready=1 -> next instruction accepted the same cycle.
REQ-036 Accept add reading x1 in the same cycle as wb x1=0x55 -> read_data1=0x55 with R_DECODE_BYPASS_EN, 9 without.
REQ-037 wb x0=0xFFFF then read x0 -> 0; assert rst_n=0 while a bundle is held -> out_valid=0 next cycle, x1 reads 0.
